amplitude_seq_ctrl: RTL and testbench

Parametrised sequencer for the MFCC amplitude stage. It walks a configurable number of spectral bins and, for each bin, drives read, compare (max/min FP), multiply, add and write phases. Phase lengths are set by parameters. Wait and loop counting are done internally instead of through external counter blocks. A start/busy/done handshake and a synchronous abort are provided so the top-level MFCC controller can chain frames.

---
 rtl/amplitude_seq_ctrl.sv | 245 ++++++++++++++++++++++++
 tb/tb_amplitude_seq_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/amplitude_seq_ctrl.sv
// -----------------------------------------------------------------------------
// amplitude_seq_ctrl
//
// Purpose:
//   Frame sequencer for the MFCC amplitude stage. For each of bins_cfg
//   spectral bins it steps through READ, CMP (max/min FP enable), MUL, ADD and
//   WRITE. Each timed phase lasts LAT_x cycles, counted by one internal phase
//   counter. A start/busy/done handshake and a synchronous abort let the MFCC
//   top-level controller chain frames.
//
// Handshake:
//   start is sampled only in IDLE. The accepting edge latches bins_cfg,
//   rd_base and wr_base, and busy rises. busy stays high until the single DONE
//   cycle (done=1) has completed. start seen in any other state, including the
//   DONE cycle, is dropped and not queued. abort returns to IDLE on the next
//   edge from any state without producing a done pulse.
//
// Optional feature (macro AMP_SEQ_STALL_EN):
//   Adds input stall. While stall=1 the state, phase counter and bin index
//   hold and all phase strobes are forced low. busy and done are unaffected,
//   the DONE cycle is never extended, and abort still takes effect.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start, abort         frame request (IDLE only), synchronous abort
//   stall                (AMP_SEQ_STALL_EN only) pipeline hold
//   bins_cfg             number of bins per frame
//   rd_base, wr_base     read / write base addresses
//   busy, done           frame in progress, one-cycle end-of-frame pulse
//   bin_idx              current bin index
//   rd_addr, wr_addr     rd_base + bin_idx, wr_base + bin_idx (mod 2^ADDR_WIDTH)
//   rd_en .. wr_en       one-hot-or-zero phase strobes
//   dbg_state            current FSM state encoding
// -----------------------------------------------------------------------------
module amplitude_seq_ctrl #(
    parameter int ADDR_WIDTH = 12,
    parameter int CNT_WIDTH  = 4,
    parameter int LAT_READ   = 2,
    parameter int LAT_CMP    = 10,
    parameter int LAT_MUL    = 10,
    parameter int LAT_ADD    = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
`ifdef AMP_SEQ_STALL_EN
    input  logic                  stall,
`endif
    input  logic [ADDR_WIDTH-1:0] bins_cfg,
    input  logic [ADDR_WIDTH-1:0] rd_base,
    input  logic [ADDR_WIDTH-1:0] wr_base,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] bin_idx,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic                  rd_en,
    output logic                  cmp_en,
    output logic                  mul_en,
    output logic                  add_en,
    output logic                  wr_en,
    output logic [2:0]            dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_READ  = 3'd2,
        S_CMP   = 3'd3,
        S_MUL   = 3'd4,
        S_ADD   = 3'd5,
        S_WRITE = 3'd6,
        S_DONE  = 3'd7
    } state_t;

    // A latency of 0 behaves as 1; the counter is loaded with LAT-1 so the
    // phase leaves on the cycle the counter reads zero.
    localparam int LR_EFF = (LAT_READ == 0) ? 1 : LAT_READ;
    localparam int LC_EFF = (LAT_CMP  == 0) ? 1 : LAT_CMP;
    localparam int LM_EFF = (LAT_MUL  == 0) ? 1 : LAT_MUL;
    localparam int LA_EFF = (LAT_ADD  == 0) ? 1 : LAT_ADD;

    localparam logic [CNT_WIDTH-1:0]  LD_READ = CNT_WIDTH'(LR_EFF - 1);
    localparam logic [CNT_WIDTH-1:0]  LD_CMP  = CNT_WIDTH'(LC_EFF - 1);
    localparam logic [CNT_WIDTH-1:0]  LD_MUL  = CNT_WIDTH'(LM_EFF - 1);
    localparam logic [CNT_WIDTH-1:0]  LD_ADD  = CNT_WIDTH'(LA_EFF - 1);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE = CNT_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] IDX_ONE = ADDR_WIDTH'(1);

    if (LAT_READ > (2 ** CNT_WIDTH) || LAT_CMP > (2 ** CNT_WIDTH) ||
        LAT_MUL  > (2 ** CNT_WIDTH) || LAT_ADD > (2 ** CNT_WIDTH)) begin : g_lat_check
        $error("amplitude_seq_ctrl: a phase latency does not fit in CNT_WIDTH");
    end

    state_t                r_state;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [ADDR_WIDTH-1:0] r_bin;
    logic [ADDR_WIDTH-1:0] r_bins;
    logic [ADDR_WIDTH-1:0] r_rd_base;
    logic [ADDR_WIDTH-1:0] r_wr_base;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_rd_en;
    logic                  r_cmp_en;
    logic                  r_mul_en;
    logic                  r_add_en;
    logic                  r_wr_en;

    state_t                w_next_state;
    logic [CNT_WIDTH-1:0]  w_next_cnt;
    logic [ADDR_WIDTH-1:0] w_next_bin;
    logic                  w_latch;
    logic                  w_stall;

`ifdef AMP_SEQ_STALL_EN
    assign w_stall = stall;
`else
    assign w_stall = 1'b0;
`endif

    // Next-state / counter / bin-index logic
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_next_bin   = r_bin;
        w_latch      = 1'b0;
        if (abort) begin
            w_next_state = S_IDLE;
        end else if (w_stall && (r_state != S_DONE)) begin
            // hold everything; DONE always completes in one cycle
            w_next_state = r_state;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_next_state = S_LOAD;
                        w_latch      = 1'b1;
                        w_next_bin   = '0;
                    end
                end
                S_LOAD: begin
                    if (r_bins == '0) begin
                        w_next_state = S_DONE;
                    end else begin
                        w_next_state = S_READ;
                        w_next_cnt   = LD_READ;
                    end
                end
                S_READ: begin
                    if (r_cnt == '0) begin
                        w_next_state = S_CMP;
                        w_next_cnt   = LD_CMP;
                    end else begin
                        w_next_cnt = r_cnt - CNT_ONE;
                    end
                end
                S_CMP: begin
                    if (r_cnt == '0) begin
                        w_next_state = S_MUL;
                        w_next_cnt   = LD_MUL;
                    end else begin
                        w_next_cnt = r_cnt - CNT_ONE;
                    end
                end
                S_MUL: begin
                    if (r_cnt == '0) begin
                        w_next_state = S_ADD;
                        w_next_cnt   = LD_ADD;
                    end else begin
                        w_next_cnt = r_cnt - CNT_ONE;
                    end
                end
                S_ADD: begin
                    if (r_cnt == '0) begin
                        w_next_state = S_WRITE;
                    end else begin
                        w_next_cnt = r_cnt - CNT_ONE;
                    end
                end
                S_WRITE: begin
                    if (r_bin == (r_bins - IDX_ONE)) begin
                        w_next_state = S_DONE;
                    end else begin
                        w_next_state = S_READ;
                        w_next_cnt   = LD_READ;
                        w_next_bin   = r_bin + IDX_ONE;
                    end
                end
                S_DONE:  w_next_state = S_IDLE;
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    // State, counters, latched configuration and registered outputs.
    // Outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bin     <= '0;
            r_bins    <= '0;
            r_rd_base <= '0;
            r_wr_base <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_rd_en   <= 1'b0;
            r_cmp_en  <= 1'b0;
            r_mul_en  <= 1'b0;
            r_add_en  <= 1'b0;
            r_wr_en   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            r_bin   <= w_next_bin;
            if (w_latch) begin
                r_bins    <= bins_cfg;
                r_rd_base <= rd_base;
                r_wr_base <= wr_base;
            end
            r_busy   <= (w_next_state != S_IDLE);
            r_done   <= (w_next_state == S_DONE);
            r_rd_en  <= (w_next_state == S_READ);
            r_cmp_en <= (w_next_state == S_CMP);
            r_mul_en <= (w_next_state == S_MUL);
            r_add_en <= (w_next_state == S_ADD);
            r_wr_en  <= (w_next_state == S_WRITE);
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign bin_idx   = r_bin;
    assign rd_addr   = r_rd_base + r_bin;
    assign wr_addr   = r_wr_base + r_bin;
    // strobes are suppressed for the cycles the pipeline is held
    assign rd_en     = r_rd_en  & ~w_stall;
    assign cmp_en    = r_cmp_en & ~w_stall;
    assign mul_en    = r_mul_en & ~w_stall;
    assign add_en    = r_add_en & ~w_stall;
    assign wr_en     = r_wr_en  & ~w_stall;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_amplitude_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_amplitude_seq_ctrl
//
// Directed bench for amplitude_seq_ctrl with default parameters. Inputs are
// driven on the falling edge, outputs sampled on the falling edge. A monitor
// logs strobe counts and write/read addresses; expected values are constants
// worked out by hand from the sequencing rules.
// -----------------------------------------------------------------------------
module tb_amplitude_seq_ctrl;

    localparam int AW = 12;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_CMP  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd7;

    // clock / reset
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          start    = 1'b0;
    logic          abort    = 1'b0;
    logic [AW-1:0] bins_cfg = '0;
    logic [AW-1:0] rd_base  = '0;
    logic [AW-1:0] wr_base  = '0;
`ifdef AMP_SEQ_STALL_EN
    logic          stall    = 1'b0;
`endif
    logic          busy, done, rd_en, cmp_en, mul_en, add_en, wr_en;
    logic [AW-1:0] bin_idx, rd_addr, wr_addr;
    logic [2:0]    dbg_state;

    amplitude_seq_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
`ifdef AMP_SEQ_STALL_EN
        .stall     (stall),
`endif
        .bins_cfg  (bins_cfg),
        .rd_base   (rd_base),
        .wr_base   (wr_base),
        .busy      (busy),
        .done      (done),
        .bin_idx   (bin_idx),
        .rd_addr   (rd_addr),
        .wr_addr   (wr_addr),
        .rd_en     (rd_en),
        .cmp_en    (cmp_en),
        .mul_en    (mul_en),
        .add_en    (add_en),
        .wr_en     (wr_en),
        .dbg_state (dbg_state)
    );

    // monitor
    int            n_rd = 0, n_cmp = 0, n_add = 0, n_wr = 0, n_done = 0, n_multi = 0;
    int            cyc = 0;
    logic [AW-1:0] wr_log[$];
    logic [AW-1:0] rd_log[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rd_en) begin
            n_rd++;
            rd_log.push_back(rd_addr);
        end
        if (cmp_en) n_cmp++;
        if (add_en) n_add++;
        if (wr_en) begin
            n_wr++;
            wr_log.push_back(wr_addr);
        end
        if (done) n_done++;
        if ($countones({rd_en, cmp_en, mul_en, add_en, wr_en}) > 1) n_multi++;
    end

    // scoreboard
    int            checks   = 0;
    int            failures = 0;
    logic [AW-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    // Presents config with start before an edge; returns just after the accept edge.
    task automatic cfg_start(input logic [AW-1:0] b, input logic [AW-1:0] r,
                             input logic [AW-1:0] w, input logic hold_start);
        @(negedge clk);
        bins_cfg = b;
        rd_base  = r;
        wr_base  = w;
        start    = 1'b1;
        @(posedge clk);
        #1;
        if (!hold_start) start = 1'b0;
    endtask

    // Counts edges after the accept edge until done is seen; -1 on timeout.
    task automatic wait_done(input int limit, output int lat);
        lat = 0;
        while (lat < limit) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (done) break;
        end
        if (!done) lat = -1;
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_busy"},    32'(busy), 32'd0);
        chk({tag, "_done"},    32'(done), 32'd0);
        chk({tag, "_strobes"}, 32'({rd_en, cmp_en, mul_en, add_en, wr_en}), 32'd0);
        chk({tag, "_state"},   32'(dbg_state), 32'(ST_IDLE));
    endtask

    int lat;
    int b_rd, b_cmp, b_wr, b_done, b_wrlog, b_rdlog;
    int k;

    initial begin
        // ---- reset state ----
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_quiet("reset");
        chk("reset_bin_idx", 32'(bin_idx), 32'd0);
        chk("reset_rd_addr", 32'(rd_addr), 32'd0);
        chk("reset_wr_addr", 32'(wr_addr), 32'd0);
        rst_n = 1'b1;

        // ---- 3 bins, default latencies ----
        b_rd = n_rd; b_cmp = n_cmp; b_wr = n_wr; b_wrlog = wr_log.size();
        cfg_start(12'd3, 12'h100, 12'h200, 1'b0);
        wait_done(200, lat);
        chk("f3_latency", 32'(lat), 32'd100);
        chk("f3_busy_in_done", 32'(busy), 32'd1);
        @(negedge clk);
        check_quiet("f3_after");
        #1;
        chk("f3_wr_count", 32'(n_wr - b_wr), 32'd3);
        chk("f3_cmp_count", 32'(n_cmp - b_cmp), 32'd30);
        chk("f3_rd_count", 32'(n_rd - b_rd), 32'd6);
        exp_q.push_back(12'h200);
        exp_q.push_back(12'h201);
        exp_q.push_back(12'h202);
        for (int i = 0; i < 3; i++) begin
            chk("f3_wr_addr", 32'(wr_log[b_wrlog + i]), 32'(exp_q.pop_front()));
        end

        // ---- zero bins: LOAD then DONE ----
        b_rd = n_rd; b_wr = n_wr;
        cfg_start(12'd0, 12'h010, 12'h020, 1'b0);
        wait_done(20, lat);
        chk("f0_latency", 32'(lat), 32'd1);
        #1;
        chk("f0_rd_count", 32'(n_rd - b_rd), 32'd0);
        chk("f0_wr_count", 32'(n_wr - b_wr), 32'd0);
        @(negedge clk);

        // ---- address wrap ----
        b_rdlog = rd_log.size(); b_wrlog = wr_log.size();
        cfg_start(12'd2, 12'hFFF, 12'hFFE, 1'b0);
        wait_done(200, lat);
        chk("wrap_latency", 32'(lat), 32'd67);
        #1;
        chk("wrap_rd_bin0", 32'(rd_log[b_rdlog]), 32'h0FFF);
        chk("wrap_rd_bin1", 32'(rd_log[b_rdlog + 2]), 32'h0000);
        chk("wrap_wr_bin0", 32'(wr_log[b_wrlog]), 32'h0FFE);
        chk("wrap_wr_bin1", 32'(wr_log[b_wrlog + 1]), 32'h0FFF);
        @(negedge clk);

        // ---- start held through DONE is only taken from IDLE ----
        cfg_start(12'd0, 12'h000, 12'h000, 1'b1);
        @(negedge clk);
        chk("dstart_load", 32'(dbg_state), 32'(ST_LOAD));
        @(negedge clk);
        chk("dstart_done_state", 32'(dbg_state), 32'(ST_DONE));
        chk("dstart_done_pulse", 32'(done), 32'd1);
        @(negedge clk);
        chk("dstart_idle", 32'(dbg_state), 32'(ST_IDLE));
        chk("dstart_idle_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("dstart_reaccept", 32'(dbg_state), 32'(ST_LOAD));
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("dstart_end", 32'(dbg_state), 32'(ST_IDLE));

        // ---- abort in CMP of bin 0, start held high ----
        b_wr = n_wr; b_done = n_done;
        cfg_start(12'd4, 12'h300, 12'h400, 1'b1);
        k = 0;
        while (k < 20) begin
            @(negedge clk);
            k++;
            if (cmp_en) break;
        end
        chk("abort_reached_cmp", 32'(cmp_en), 32'd1);
        chk("abort_state_cmp", 32'(dbg_state), 32'(ST_CMP));
        chk("abort_bin0", 32'(bin_idx), 32'd0);
        abort = 1'b1;
        @(negedge clk);
        check_quiet("abort_next");
        abort = 1'b0;
        @(negedge clk);
        chk("abort_reaccept", 32'(dbg_state), 32'(ST_LOAD));
        abort = 1'b1;
        @(negedge clk);
        chk("abort_load_idle", 32'(dbg_state), 32'(ST_IDLE));
        // abort and start together in IDLE stay in IDLE
        @(negedge clk);
        check_quiet("abort_start_idle");
        start = 1'b0;
        abort = 1'b0;
        #1;
        chk("abort_no_wr", 32'(n_wr - b_wr), 32'd0);
        chk("abort_no_done", 32'(n_done - b_done), 32'd0);

        // ---- reset during MUL of bin 1 ----
        cfg_start(12'd3, 12'h100, 12'h200, 1'b0);
        k = 0;
        while (k < 100) begin
            @(negedge clk);
            k++;
            if (mul_en && bin_idx == 12'd1) break;
        end
        chk("rst_reached_mul1", 32'(mul_en), 32'd1);
        rst_n = 1'b0;
        #1;
        check_quiet("rst_mid");
        chk("rst_mid_bin_idx", 32'(bin_idx), 32'd0);
        chk("rst_mid_rd_addr", 32'(rd_addr), 32'd0);
        chk("rst_mid_wr_addr", 32'(wr_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        b_wr = n_wr; b_wrlog = wr_log.size(); b_rdlog = rd_log.size();
        cfg_start(12'd1, 12'h010, 12'h020, 1'b0);
        wait_done(100, lat);
        chk("rst_rerun_latency", 32'(lat), 32'd34);
        #1;
        chk("rst_rerun_wr_count", 32'(n_wr - b_wr), 32'd1);
        chk("rst_rerun_wr_addr", 32'(wr_log[b_wrlog]), 32'h020);
        chk("rst_rerun_rd_addr", 32'(rd_log[b_rdlog]), 32'h010);
        @(negedge clk);

`ifdef AMP_SEQ_STALL_EN
        // ---- stall for 5 cycles during ADD ----
        begin
            int acc_cyc;
            b_cmp = n_add;
            cfg_start(12'd1, 12'h000, 12'h000, 1'b0);
            acc_cyc = cyc;
            k = 0;
            while (k < 60) begin
                @(negedge clk);
                k++;
                if (add_en) break;
            end
            stall = 1'b1;
            #1;
            chk("stall_add_low", 32'(add_en), 32'd0);
            repeat (5) @(negedge clk);
            stall = 1'b0;
            k = 0;
            while (k < 60) begin
                if (done) break;
                @(negedge clk);
                k++;
            end
            chk("stall_latency", 32'(cyc - acc_cyc), 32'd39);
            #1;
            chk("stall_add_count", 32'(n_add - b_cmp), 32'd10);
            @(negedge clk);
        end
`endif

        #1;
        chk("onehot_strobes", 32'(n_multi), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
